// File: rtl/serial_sub.sv
// serial_sub: bit-serial two's-complement subtractor.
//   Computes diff = a - b one bit per clock, LSB first, through a single
//   full-subtractor cell with a registered borrow. Start/done handshake.
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous reset, active-low
//   start   request, sampled only in IDLE
//   a, b    minuend / subtrahend, captured on accepted start
//   busy    high while the bit loop is running
//   done    one-cycle pulse, result valid
//   diff    a - b mod 2^WIDTH, held until next completion
//   borrow  unsigned borrow-out (a < b), held
//   ovf     signed overflow of a - b, held
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, borrow_q, borrow_d, ovf_q, ovf_d;
    logic             amsb_q, amsb_d, bmsb_q, bmsb_d;

    // Full-subtractor cell on the current LSBs.
    logic x, y, dbit, bnext;
    assign x     = sa_q[0];
    assign y     = sb_q[0];
    assign dbit  = x ^ y ^ br_q;
    assign bnext = (~x & y) | (~(x ^ y) & br_q);

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        amsb_d   = amsb_q;
        bmsb_d   = bmsb_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
                    state_d = RUN;
                end
            end
            RUN: begin
                // Result bits enter at the MSB; after WIDTH shifts bit 0 is at the LSB.
                res_d = {dbit, res_q[WIDTH-1:1]};
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = bnext;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d   = res_d;
                    borrow_d = bnext;
                    // Overflow only possible when operand signs differ; the
                    // result sign (last cell output) must then follow a.
                    ovf_d    = (amsb_q != bmsb_q) && (dbit != amsb_q);
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            amsb_q   <= amsb_d;
            bmsb_q   <= bmsb_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: an 8-bit instance for directed, handshake,
// reset and random tests, and a 4-bit instance for the exhaustive sweep.
module tb_serial_sub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start8 = 1'b0, start4 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy8, done8, borrow8, ovf8;
    logic       busy4, done4, borrow4, ovf4;
    logic [7:0] diff8;
    logic [3:0] diff4;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .ovf(ovf8)
    );

    serial_sub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .ovf(ovf4)
    );

    typedef struct {
        logic [7:0] d;
        logic       br;
        logic       ov;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    exp_t last8;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t ref_model(input int w, input int av, input int bv);
        exp_t e;
        int   m, sa, sb, sd;
        m    = 1 << w;
        e.d  = 8'((av - bv + m) % m);
        e.br = (av < bv);
        sa   = (av >= m / 2) ? av - m : av;
        sb   = (bv >= m / 2) ? bv - m : bv;
        sd   = sa - sb;
        e.ov = (sd < -(m / 2)) || (sd > m / 2 - 1);
        return e;
    endfunction

    // Monitors: pop and compare whenever a DUT pulses done.
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) chk("dut8_unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q8.pop_front();
                chk("dut8_diff", diff8, e.d);
                chk("dut8_borrow", borrow8, e.br);
                chk("dut8_ovf", ovf8, e.ov);
                chk("dut8_busy_with_done", busy8, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) chk("dut4_unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q4.pop_front();
                chk("dut4_diff", diff4, e.d[3:0]);
                chk("dut4_borrow", borrow4, e.br);
                chk("dut4_ovf", ovf4, e.ov);
            end
        end
    end

    // One 8-bit transaction; returns one edge before the earliest next start.
    // ign: also pulse start with junk operands mid-RUN and in DONE.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit ign);
        exp_t e;
        e = ref_model(8, av, bv);
        start8 = 1'b1; a8 = av; b8 = bv;
        q8.push_back(e);
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        for (int i = 1; i <= 8; i++) begin
            if (ign && i == 3) begin
                start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
            end
            @(posedge clk); #1;
            start8 = 1'b0;
            if (i == 3) chk("diff_held_during_run", diff8, last8.d);
            if (i < 8) begin
                chk("busy_in_run", busy8, 1);
                chk("no_early_done", done8, 0);
            end else begin
                chk("done_at_T_plus_W", done8, 1);
            end
        end
        if (ign) begin
            start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
        end
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("done_one_cycle", done8, 0);
        chk("start_in_done_ignored", busy8, 0);
        last8 = e;
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv);
        start4 = 1'b1; a4 = av; b4 = bv;
        q4.push_back(ref_model(4, av, bv));
        @(posedge clk); #1;
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        last8.d = 8'h00; last8.br = 1'b0; last8.ov = 1'b0;

        // Reset held 3 cycles, then released.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_diff", diff8, 8'h00);
        chk("rst_borrow", borrow8, 0);
        chk("rst_ovf", ovf8, 0);

        // Directed operand patterns and boundaries.
        op8(8'h05, 8'h03, 1'b0);
        op8(8'h03, 8'h05, 1'b0);
        op8(8'h80, 8'h01, 1'b0);
        op8(8'h7F, 8'hFF, 1'b0);
        op8(8'h5A, 8'h5A, 1'b0);
        op8(8'hC3, 8'h00, 1'b0);
        op8(8'h00, 8'h01, 1'b0);
        // Handshake: stray starts during RUN and DONE are dropped.
        op8(8'h12, 8'h34, 1'b1);
        op8(8'h44, 8'h11, 1'b0);

        // Reset mid-RUN at T+4: abort, outputs cleared, no done.
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrun_rst_busy", busy8, 0);
        chk("midrun_rst_done", done8, 0);
        chk("midrun_rst_diff", diff8, 8'h00);
        chk("midrun_rst_borrow", borrow8, 0);
        chk("midrun_rst_ovf", ovf8, 0);
        rst_n = 1'b1;
        last8.d = 8'h00; last8.br = 1'b0; last8.ov = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        op8(8'h10, 8'h20, 1'b0);

        // Random back-to-back at the earliest legal start edge.
        for (int n = 0; n < 40; n++) op8(8'($urandom), 8'($urandom), 1'b0);

        // Exhaustive 4-bit sweep, back-to-back.
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                op4(4'(i), 4'(j));

        repeat (4) @(posedge clk);
        #1;
        chk("q8_drained", q8.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
